prio_heap_queue: RTL and testbench

- Parametrised successor to the single-port label-priority FIFO.
- A binary-heap priority queue keyed on the top KEY_WIDTH bits of each entry. It uses valid/ready handshakes on both sides and a selectable min/max ordering mode.
- Supports push, pop, simultaneous replace (push+pop in one cycle) and synchronous flush.
- Sits between per-port packet classifiers and the EDF output scheduler.

---
 rtl/prio_heap_queue.sv | 170 +++++++++++++++++
 tb/tb_prio_heap_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prio_heap_queue.sv
// Binary-heap priority queue keyed on the top KEY_WIDTH bits of each entry.
// Sifts one heap level per cycle; supports push, pop, replace-root and flush.
module prio_heap_queue #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int KEY_WIDTH  = 8,
    parameter bit MAX_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int IW    = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
    localparam logic [IW-1:0]         W_ONE    = IW'(1);

    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

    // Ties are deliberately not "better" so equal keys never swap.
    function automatic logic better(input logic [KEY_WIDTH-1:0] a,
                                    input logic [KEY_WIDTH-1:0] b);
        if (MAX_FIRST) return a > b;
        else           return a < b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   count_nx;
    logic [ADDR_WIDTH-1:0] cur_idx, cur_nx;
    logic [DATA_WIDTH-1:0] hold_data, hold_nx;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  push_fire, pop_fire;
    logic [ADDR_WIDTH:0]   cnt_p1, cnt_m1;
    logic [ADDR_WIDTH-1:0] par_idx, c_idx;
    logic [IW-1:0]         lft_w, rgt_w, cnt_w;
    logic                  r_in, pick_r;
    logic [DATA_WIDTH-1:0] mem_par, mem_l, mem_r, c_data;
    logic [KEY_WIDTH-1:0]  key_hold, key_par, key_l, key_r, key_c;

    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign busy      = (state != IDLE);
    assign out_valid = (state == IDLE) && !empty;
    assign in_ready  = (state == IDLE) && (!full || (out_valid && out_ready));
    assign out_data  = mem[0];

    assign push_fire = in_valid && in_ready;
    assign pop_fire  = out_valid && out_ready;
    assign cnt_p1    = count + CNT_ONE;
    assign cnt_m1    = count - CNT_ONE;

    // Wide index arithmetic so 2i+2 can never wrap back into the array.
    assign par_idx = (cur_idx - IDX_ONE) >> 1;
    assign lft_w   = ({2'b00, cur_idx} << 1) + W_ONE;
    assign rgt_w   = lft_w + W_ONE;
    assign cnt_w   = {1'b0, count};
    assign r_in    = (rgt_w < cnt_w);

    assign mem_par = mem[par_idx];
    assign mem_l   = mem[lft_w[ADDR_WIDTH-1:0]];
    assign mem_r   = mem[rgt_w[ADDR_WIDTH-1:0]];

    assign key_hold = hold_data[DATA_WIDTH-1 -: KEY_WIDTH];
    assign key_par  = mem_par[DATA_WIDTH-1 -: KEY_WIDTH];
    assign key_l    = mem_l[DATA_WIDTH-1 -: KEY_WIDTH];
    assign key_r    = mem_r[DATA_WIDTH-1 -: KEY_WIDTH];

    assign pick_r = r_in && better(key_r, key_l);
    assign c_idx  = pick_r ? rgt_w[ADDR_WIDTH-1:0] : lft_w[ADDR_WIDTH-1:0];
    assign c_data = pick_r ? mem_r : mem_l;
    assign key_c  = c_data[DATA_WIDTH-1 -: KEY_WIDTH];

    always_comb begin
        state_nx = state;
        count_nx = count;
        cur_nx   = cur_idx;
        hold_nx  = hold_data;
        wr_en    = 1'b0;
        wr_addr  = cur_idx;
        wr_data  = hold_data;
        if (flush) begin
            state_nx = IDLE;
            count_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push_fire && pop_fire) begin
                        hold_nx  = in_data;
                        cur_nx   = '0;
                        state_nx = SIFT_DOWN;
                    end else if (push_fire) begin
                        wr_en    = 1'b1;
                        wr_addr  = count[ADDR_WIDTH-1:0];
                        wr_data  = in_data;
                        count_nx = cnt_p1;
                        if (!empty) begin
                            cur_nx   = count[ADDR_WIDTH-1:0];
                            hold_nx  = in_data;
                            state_nx = SIFT_UP;
                        end
                    end else if (pop_fire) begin
                        count_nx = cnt_m1;
                        if (count != CNT_ONE) begin
                            hold_nx  = mem[cnt_m1[ADDR_WIDTH-1:0]];
                            cur_nx   = '0;
                            state_nx = SIFT_DOWN;
                        end
                    end
                end
                SIFT_UP: begin
                    wr_en = 1'b1;
                    if (cur_idx == '0 || !better(key_hold, key_par)) begin
                        state_nx = IDLE;
                    end else begin
                        wr_data = mem_par;
                        cur_nx  = par_idx;
                    end
                end
                SIFT_DOWN: begin
                    wr_en = 1'b1;
                    if (lft_w >= cnt_w || !better(key_c, key_hold)) begin
                        state_nx = IDLE;
                    end else begin
                        wr_data = c_data;
                        cur_nx  = c_idx;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Control state: async reset; heap storage below is never reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            cur_idx   <= '0;
            hold_data <= '0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            cur_idx   <= cur_nx;
            hold_data <= hold_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_prio_heap_queue.sv
// Scoreboard bench: dut0 is a min-first queue, dut1 a max-first queue.
module tb_prio_heap_queue;
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        flush = '0, in_valid = '0, out_ready = '0;
    logic [1:0]        in_ready, out_valid, full, empty, busy;
    logic [15:0]       in_data [2];
    logic [15:0]       out_data [2];
    logic [4:0]        count [2];

    int                n_checks = 0;
    int                n_fail = 0;
    logic [15:0]       exp0 [$];
    logic [15:0]       exp1 [$];

    always #5 clk = ~clk;

    prio_heap_queue #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .KEY_WIDTH(8), .MAX_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .count(count[0]), .full(full[0]), .empty(empty[0]), .busy(busy[0])
    );

    prio_heap_queue #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .KEY_WIDTH(8), .MAX_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .count(count[1]), .full(full[1]), .empty(empty[1]), .busy(busy[1])
    );

    function automatic logic [15:0] mk(input logic [7:0] k);
        return {k, ~k};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst && !flush[0] && out_valid[0] && out_ready[0]) begin
            if (exp0.size() == 0) check("pop0_unexpected", 32'(out_data[0]), 32'hFFFF_FFFF);
            else check("pop0_data", 32'(out_data[0]), 32'(exp0.pop_front()));
        end
        if (rst && !flush[1] && out_valid[1] && out_ready[1]) begin
            if (exp1.size() == 0) check("pop1_unexpected", 32'(out_data[1]), 32'hFFFF_FFFF);
            else check("pop1_data", 32'(out_data[1]), 32'(exp1.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy[d] && n < 20) begin
            step();
            n++;
        end
        if (busy[d]) check("idle_timeout", 32'(busy[d]), 32'd0);
    endtask

    task automatic push(input int d, input logic [7:0] k);
        wait_idle(d);
        in_valid[d] = 1'b1;
        in_data[d]  = mk(k);
        step();
        in_valid[d] = 1'b0;
    endtask

    task automatic pop(input int d, input logic [7:0] k);
        wait_idle(d);
        if (d == 0) exp0.push_back(mk(k));
        else        exp1.push_back(mk(k));
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] keys [4];
        in_data[0] = '0;
        in_data[1] = '0;

        // Reset values are visible before any clock edge.
        #3;
        check("rst_count", 32'(count[0]), 32'd0);
        check("rst_empty", 32'(empty[0]), 32'd1);
        check("rst_full", 32'(full[0]), 32'd0);
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        #9 rst = 1'b1;
        step();

        // Min-first ordering.
        keys = '{8'd5, 8'd3, 8'd7, 8'd1};
        foreach (keys[i]) push(0, keys[i]);
        wait_idle(0);
        check("four_count", 32'(count[0]), 32'd4);
        pop(0, 8'd1);
        pop(0, 8'd3);
        pop(0, 8'd5);
        pop(0, 8'd7);
        check("drain_count", 32'(count[0]), 32'd0);
        check("drain_empty", 32'(empty[0]), 32'd1);

        // Fill to capacity with descending keys.
        for (int k = 15; k >= 0; k--) push(0, 8'(k));
        wait_idle(0);
        check("fill_count", 32'(count[0]), 32'd16);
        check("fill_full", 32'(full[0]), 32'd1);
        check("fill_in_ready", 32'(in_ready[0]), 32'd0);
        in_valid[0] = 1'b1;
        in_data[0]  = mk(8'h20);
        step();
        in_valid[0] = 1'b0;
        check("full_reject_count", 32'(count[0]), 32'd16);

        // Replace-root while full: head 0x00 leaves, 0x02 enters.
        exp0.push_back(mk(8'h00));
        in_valid[0]  = 1'b1;
        in_data[0]   = mk(8'h02);
        out_ready[0] = 1'b1;
        step();
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        n = 0;
        while (busy[0] && n < 10) begin
            step();
            n++;
        end
        check("replace_busy_le4", 32'(n <= 4), 32'd1);
        check("replace_count", 32'(count[0]), 32'd16);
        check("replace_head", 32'(out_data[0]), 32'(mk(8'h01)));
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        check("flush_count", 32'(count[0]), 32'd0);

        // Max-first ordering on the second instance.
        keys = '{8'd10, 8'd40, 8'd20, 8'd30};
        foreach (keys[i]) push(1, keys[i]);
        pop(1, 8'd40);
        pop(1, 8'd30);
        pop(1, 8'd20);
        pop(1, 8'd10);
        check("max_drain_empty", 32'(empty[1]), 32'd1);

        // Flush in the middle of a sift-up.
        for (int k = 8; k >= 1; k--) push(0, 8'(k));
        check("sift_up_busy", 32'(busy[0]), 32'd1);
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        check("mid_flush_count", 32'(count[0]), 32'd0);
        check("mid_flush_empty", 32'(empty[0]), 32'd1);
        check("mid_flush_out_valid", 32'(out_valid[0]), 32'd0);
        check("mid_flush_busy", 32'(busy[0]), 32'd0);
        push(0, 8'd9);
        pop(0, 8'd9);

        // Asynchronous reset in the middle of a sift-down.
        keys = '{8'd1, 8'd2, 8'd3, 8'd4};
        foreach (keys[i]) push(0, keys[i]);
        pop(0, 8'd1);
        check("sift_down_busy", 32'(busy[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_in_ready", 32'(in_ready[0]), 32'd1);
        check("async_out_valid", 32'(out_valid[0]), 32'd0);
        check("async_count", 32'(count[0]), 32'd0);
        check("async_busy", 32'(busy[0]), 32'd0);
        #3 rst = 1'b1;
        step();
        push(0, 8'd6);
        pop(0, 8'd6);
        wait_idle(0);

        check("scoreboard0_drained", 32'(exp0.size()), 32'd0);
        check("scoreboard1_drained", 32'(exp1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
